// File: rtl/lsu_mem.sv
// Memory-access stage: bus transaction for loads/stores, combinational pass-through otherwise.
// Latency: 4 cycles per access minimum (IDLE, REQ, RSP, DONE); non-memory ops take 0 extra cycles.
// Backpressure: stall_req_o holds upstream while a transaction is open; optional timeout via LSU_TIMEOUT_EN.
module lsu_mem
`ifdef LSU_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_wa_i,
    input  logic [31:0] rd_wd_i,
    input  logic        csr_we_i,
    input  logic [31:0] csr_wa_i,
    input  logic [31:0] csr_wd_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_wa_o,
    output logic [31:0] rd_wd_o,
    output logic        csr_we_o,
    output logic [31:0] csr_wa_o,
    output logic [31:0] csr_wd_o,
    output logic        stall_req_o,
    output logic        dbus_req_o,
    input  logic        dbus_gnt_i,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_rvalid_i,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_err_i,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] exc_addr_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_DONE, S_DRAIN} state_t;

    state_t      state;
    logic        is_ld, is_st, size_b, size_h, size_w;
    logic        is_mem, misaligned;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] addr_q, rdata_q, ext;
    logic [3:0]  op_q;
    logic [4:0]  wa_q;
    logic        err_q;
    logic        to_hit;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign csr_we_o = csr_we_i;
    assign csr_wa_o = csr_wa_i;
    assign csr_wd_o = csr_wd_i;

    // Decode the operation into direction and access size; unknown encodings act as NONE.
    always_comb begin
        is_ld  = 1'b0;
        is_st  = 1'b0;
        size_b = 1'b0;
        size_h = 1'b0;
        size_w = 1'b0;
        case (mem_op_i)
            4'b0001, 4'b0100: begin is_ld = 1'b1; size_b = 1'b1; end
            4'b0010, 4'b0101: begin is_ld = 1'b1; size_h = 1'b1; end
            4'b0011:          begin is_ld = 1'b1; size_w = 1'b1; end
            4'b1001:          begin is_st = 1'b1; size_b = 1'b1; end
            4'b1010:          begin is_st = 1'b1; size_h = 1'b1; end
            4'b1011:          begin is_st = 1'b1; size_w = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_ld | is_st;
    assign misaligned = (size_h & mem_addr_i[0]) | (size_w & (|mem_addr_i[1:0]));

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = mem_wd_i;
        if (size_b) begin
            be_n    = 4'b0001 << mem_addr_i[1:0];
            wdata_n = {4{mem_wd_i[7:0]}};
        end else if (size_h) begin
            be_n    = 4'b0011 << {mem_addr_i[1], 1'b0};
            wdata_n = {2{mem_wd_i[15:0]}};
        end
    end

    // Pick the addressed lane from the response and extend it per the latched op.
    always_comb begin
        lane_b = dbus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (op_q)
            4'b0001: ext = {{24{lane_b[7]}}, lane_b};
            4'b0100: ext = {24'b0, lane_b};
            4'b0010: ext = {{16{lane_h[15]}}, lane_h};
            4'b0101: ext = {16'b0, lane_h};
            default: ext = dbus_rdata_i;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [4:0] tcnt;
    assign to_hit = (tcnt >= 5'(TIMEOUT - 1));

    // Cycle budget of the open transaction; zeroed while idle so it starts at 0 in REQ.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            tcnt <= '0;
        else if (state == S_IDLE)
            tcnt <= '0;
        else if (state == S_REQ || state == S_RSP || state == S_DRAIN)
            tcnt <= tcnt + 5'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Transaction FSM with registered bus outputs; responses in REQ or IDLE are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_be_o    <= 4'b0;
            dbus_addr_o  <= 32'b0;
            dbus_wdata_o <= 32'b0;
            addr_q       <= 32'b0;
            rdata_q      <= 32'b0;
            op_q         <= 4'b0;
            wa_q         <= 5'b0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!flush_i && is_mem && !misaligned) begin
                        state        <= S_REQ;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_st;
                        dbus_be_o    <= be_n;
                        dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        dbus_wdata_o <= wdata_n;
                        addr_q       <= mem_addr_i;
                        op_q         <= mem_op_i;
                        wa_q         <= rd_wa_i;
                        err_q        <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (dbus_gnt_i) begin
                        // A granted request is in flight even if flushed, so its response must be drained.
                        dbus_req_o <= 1'b0;
                        state      <= flush_i ? S_DRAIN : S_RSP;
                    end else if (flush_i) begin
                        dbus_req_o <= 1'b0;
                        state      <= S_IDLE;
                    end else if (to_hit) begin
                        dbus_req_o <= 1'b0;
                        err_q      <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_RSP: begin
                    if (dbus_rvalid_i) begin
                        rdata_q <= ext;
                        err_q   <= dbus_err_i;
                        state   <= flush_i ? S_IDLE : S_DONE;
                    end else if (flush_i) begin
                        state <= S_DRAIN;
                    end else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_DRAIN: if (dbus_rvalid_i || to_hit) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Writeback, stall and exception outputs derived from state and the held ex_mem inputs.
    always_comb begin
        stall_req_o = 1'b0;
        rd_we_o     = rd_we_i & ~is_mem;
        rd_wa_o     = rd_wa_i;
        rd_wd_o     = rd_wd_i;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        exc_addr_o  = mem_addr_i;
        case (state)
            S_IDLE: begin
                stall_req_o = is_mem & ~misaligned & ~flush_i;
                misalign_o  = is_mem & misaligned & ~flush_i;
            end
            S_REQ, S_RSP: begin
                stall_req_o = 1'b1;
                rd_we_o     = 1'b0;
            end
            S_DONE: begin
                rd_wa_o    = wa_q;
                rd_wd_o    = rdata_q;
                rd_we_o    = ~op_q[3] & ~err_q & ~flush_i;
                bus_err_o  = err_q & ~flush_i;
                exc_addr_o = addr_q;
            end
            S_DRAIN: stall_req_o = is_mem;
            default: ;
        endcase
        if (rst_i) begin
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
            bus_err_o   = 1'b0;
            rd_we_o     = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed and randomized bench for lsu_mem with a byte-level reference model.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
// The bus slave reacts to dbus_req_o with programmable grant and response delays.
module tb_lsu_mem;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wd_i;
    logic        rd_we_i, csr_we_i;
    logic [4:0]  rd_wa_i;
    logic [31:0] rd_wd_i, csr_wa_i, csr_wd_i;
    logic        rd_we_o, csr_we_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o, csr_wa_o, csr_wd_o;
    logic        stall_req_o, dbus_req_o, dbus_gnt_i, dbus_we_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i, exc_addr_o;
    logic [3:0]  dbus_be_o;
    logic        dbus_rvalid_i, dbus_err_i, misalign_o, bus_err_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] ops [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB};

    always #5 clk_i = ~clk_i;

    lsu_mem dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wd_i(mem_wd_i),
        .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i), .rd_wd_i(rd_wd_i),
        .csr_we_i(csr_we_i), .csr_wa_i(csr_wa_i), .csr_wd_i(csr_wd_i),
        .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o), .rd_wd_o(rd_wd_o),
        .csr_we_o(csr_we_o), .csr_wa_o(csr_wa_o), .csr_wd_o(csr_wd_o),
        .stall_req_o(stall_req_o),
        .dbus_req_o(dbus_req_o), .dbus_gnt_i(dbus_gnt_i), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .exc_addr_o(exc_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'h1, 4'h4, 4'h9: return 1;
            4'h2, 4'h5, 4'hA: return 2;
            4'h3, 4'hB:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op, input logic [31:0] addr);
        int s   = op_size(op);
        int off = (int'(addr % 4) / s) * s;
        return 4'(((1 << s) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int s = op_size(op);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int s = op_size(op);
        longint unsigned u = 64'(rdata) >> (8 * int'(addr % 4));
        longint v;
        if (s < 4) u = u % (64'd1 << (8 * s));
        v = longint'(u);
        if ((op == 4'h1 || op == 4'h2) && u >= (64'd1 << (8 * s - 1)))
            v = v - longint'(64'd1 << (8 * s));
        return v[31:0];
    endfunction

    task automatic clear_inputs();
        flush_i = 0; mem_op_i = 0; mem_addr_i = 0; mem_wd_i = 0;
        rd_we_i = 0; rd_wa_i = 0; rd_wd_i = 0;
        csr_we_i = 0; csr_wa_i = 0; csr_wd_i = 0;
        dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_rdata_i = 0; dbus_err_i = 0;
    endtask

    // One full access against a reactive slave: gd wait cycles before grant, rdl before response.
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rdl, input logic [31:0] rdata, input bit err,
                          input string tag);
        logic [4:0] wa = 5'($urandom);
        bit store = op[3];
        int cyc = 0, stalls = 0, wg = 0, wr = 0;
        bit granted = 0, fields_done = 0, done = 0;
        mem_op_i = op; mem_addr_i = addr; mem_wd_i = wd;
        rd_we_i = 1; rd_wa_i = wa; rd_wd_i = $urandom;
        while (!done && cyc < 200) begin
            dbus_gnt_i = 0; dbus_rvalid_i = 0;
            dbus_rdata_i = $urandom; dbus_err_i = 1'($urandom);
            if (dbus_req_o) begin
                if (wg == gd) dbus_gnt_i = 1; else wg++;
            end else if (granted) begin
                if (wr == rdl) begin
                    dbus_rvalid_i = 1; dbus_rdata_i = rdata; dbus_err_i = err;
                end else wr++;
            end
            @(negedge clk_i);
            if (!stall_req_o) done = 1;
            else begin
                stalls++;
                if (dbus_req_o && !fields_done) begin
                    fields_done = 1;
                    chk({tag, "_addr"}, dbus_addr_o, {addr[31:2], 2'b00});
                    chk({tag, "_be"}, 32'(dbus_be_o), 32'(model_be(op, addr)));
                    chk({tag, "_we"}, 32'(dbus_we_o), 32'(store));
                    if (store) chk({tag, "_wdata"}, dbus_wdata_o, model_wdata(op, wd));
                end
            end
            if (!done) begin
                tick();
                if (dbus_gnt_i) granted = 1;
                if (dbus_rvalid_i) granted = 0;
                cyc++;
            end
        end
        chk({tag, "_finished"}, 32'(done), 32'd1);
        chk({tag, "_bus_seen"}, 32'(fields_done), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(gd + rdl + 3));
        chk({tag, "_bus_err"}, 32'(bus_err_o), 32'(err));
        chk({tag, "_rd_we"}, 32'(rd_we_o), 32'(!store && !err));
        if (!store && !err) begin
            chk({tag, "_rd_wa"}, 32'(rd_wa_o), 32'(wa));
            chk({tag, "_rd_wd"}, rd_wd_o, model_load(op, addr, rdata));
        end
        if (err) chk({tag, "_exc_addr"}, exc_addr_o, addr);
        tick();
        clear_inputs();
    endtask

    task automatic misalign_step(input logic [3:0] op, input logic [31:0] addr, input string tag);
        mem_op_i = op; mem_addr_i = addr; rd_we_i = 1;
        @(negedge clk_i);
        chk({tag, "_misalign"}, 32'(misalign_o), 32'd1);
        chk({tag, "_exc_addr"}, exc_addr_o, addr);
        chk({tag, "_stall"}, 32'(stall_req_o), 32'd0);
        chk({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
        tick();
        clear_inputs();
        @(negedge clk_i);
        chk({tag, "_no_req"}, 32'(dbus_req_o), 32'd0);
        chk({tag, "_misalign_gone"}, 32'(misalign_o), 32'd0);
        tick();
    endtask

    task automatic pass_step(input logic [3:0] op, input string tag);
        logic [4:0] wa = 5'($urandom);
        logic [31:0] wd = $urandom, ca = $urandom, cd = $urandom;
        logic we = 1'($urandom), cwe = 1'($urandom);
        mem_op_i = op; mem_addr_i = $urandom;
        rd_we_i = we; rd_wa_i = wa; rd_wd_i = wd;
        csr_we_i = cwe; csr_wa_i = ca; csr_wd_i = cd;
        @(negedge clk_i);
        chk({tag, "_rd_we"}, 32'(rd_we_o), 32'(we));
        chk({tag, "_rd_wa"}, 32'(rd_wa_o), 32'(wa));
        chk({tag, "_rd_wd"}, rd_wd_o, wd);
        chk({tag, "_csr"}, {csr_we_o, csr_wa_o[30:0]}, {cwe, ca[30:0]});
        chk({tag, "_csr_wd"}, csr_wd_o, cd);
        chk({tag, "_stall"}, 32'(stall_req_o), 32'd0);
        chk({tag, "_no_req"}, 32'(dbus_req_o), 32'd0);
        tick();
        clear_inputs();
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        int          s;
        clear_inputs();
        rst_i = 1;
        tick(); tick();
        @(negedge clk_i);
        chk("rst_req", 32'(dbus_req_o), 32'd0);
        chk("rst_we", 32'(dbus_we_o), 32'd0);
        chk("rst_be", 32'(dbus_be_o), 32'd0);
        chk("rst_addr", dbus_addr_o, 32'd0);
        chk("rst_wdata", dbus_wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_req_o), 32'd0);
        chk("rst_flags", 32'({misalign_o, bus_err_o}), 32'd0);
        tick();
        rst_i = 0;

        // Directed cases
        access(4'h1, 32'h1003, 32'h0, 0, 0, 32'h80FF_FFFF, 0, "lb");
        access(4'hA, 32'h2002, 32'h1234_ABCD, 0, 0, 32'h0, 0, "sh");
        misalign_step(4'h3, 32'h2001, "lw_mis");
        misalign_step(4'hA, 32'h0003, "sh_mis");
        access(4'h5, 32'h10, 32'h0, 2, 1, 32'h0000_F00D, 0, "lhu");
        access(4'h3, 32'h44, 32'h0, 1, 2, 32'hCAFE_0001, 1, "lw_err");
        access(4'hB, 32'h48, 32'h0BAD_F00D, 0, 0, 32'h0, 1, "sw_err");
        pass_step(4'h0, "none");
        pass_step(4'h7, "bad_op");

        // Flush in RSP: response must be drained before the next access is taken
        mem_op_i = 4'h3; mem_addr_i = 32'h300; rd_we_i = 1;
        @(negedge clk_i); chk("fl_idle_stall", 32'(stall_req_o), 32'd1);
        tick(); dbus_gnt_i = 1;
        @(negedge clk_i); chk("fl_req", 32'(dbus_req_o), 32'd1);
        tick(); dbus_gnt_i = 0; flush_i = 1;
        @(negedge clk_i); chk("fl_rsp_stall", 32'(stall_req_o), 32'd1);
        tick(); flush_i = 0; mem_op_i = 4'h0; rd_we_i = 0;
        @(negedge clk_i);
        chk("drain_stall_none", 32'(stall_req_o), 32'd0);
        chk("drain_rd_we", 32'(rd_we_o), 32'd0);
        tick(); mem_op_i = 4'h3; mem_addr_i = 32'h400; rd_we_i = 1;
        @(negedge clk_i);
        chk("drain_hold", 32'(stall_req_o), 32'd1);
        chk("drain_no_req", 32'(dbus_req_o), 32'd0);
        tick();
        @(negedge clk_i); chk("drain_hold2", 32'(stall_req_o), 32'd1);
        tick(); dbus_rvalid_i = 1; dbus_rdata_i = 32'hDEAD_BEEF; dbus_err_i = 1;
        @(negedge clk_i);
        chk("drain_rv_rd_we", 32'(rd_we_o), 32'd0);
        chk("drain_rv_err", 32'(bus_err_o), 32'd0);
        tick(); dbus_rvalid_i = 0; dbus_err_i = 0;
        access(4'h3, 32'h400, 32'h0, 0, 0, 32'h1357_9BDF, 0, "after_drain");

        // Reset in the middle of a request; a late response must be ignored
        mem_op_i = 4'h3; mem_addr_i = 32'h500;
        tick();
        rst_i = 1; mem_op_i = 4'h0;
        @(negedge clk_i); chk("rst_mid_stall", 32'(stall_req_o), 32'd0);
        tick(); rst_i = 0;
        @(negedge clk_i); chk("rst_mid_req", 32'(dbus_req_o), 32'd0);
        tick(); dbus_rvalid_i = 1; dbus_rdata_i = 32'h1111_2222; dbus_err_i = 1;
        @(negedge clk_i);
        chk("late_rv_rd_we", 32'(rd_we_o), 32'd0);
        chk("late_rv_err", 32'(bus_err_o), 32'd0);
        tick(); clear_inputs();
        access(4'h2, 32'h602, 32'h0, 0, 0, 32'h8001_0000, 0, "lh_after_rst");

`ifdef LSU_TIMEOUT_EN
        begin
            int n = 0;
            bit hit = 0;
            mem_op_i = 4'h3; mem_addr_i = 32'h700;
            tick();
            while (!hit && n < 40) begin
                @(negedge clk_i);
                if (bus_err_o) hit = 1;
                else begin tick(); n++; end
            end
            chk("to_hit", 32'(hit), 32'd1);
            chk("to_cycle", 32'(n), 32'd16);
            chk("to_req_drop", 32'(dbus_req_o), 32'd0);
            tick(); clear_inputs();
            @(negedge clk_i); chk("to_idle_stall", 32'(stall_req_o), 32'd0);
            tick();
        end
`endif

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            s  = op_size(op);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(s - 1);
            if (int'(a % 4) % s != 0)
                misalign_step(op, a, "rnd_mis");
            else
                access(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                       ($urandom_range(0, 7) == 0), "rnd");
            if (i % 5 == 0) pass_step(($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF, "rnd_pass");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
